// File: rtl/sb_arbiter_pkg.sv
// Shared definitions for the system-bus arbiter: FSM state encoding,
// SPI IP register map and the default ACK watchdog limit.
package sb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_XFER,
      ST_RESP,
      ST_HOLD,
      ST_ERR
   } sb_state_e;

   // SPI IP system-bus register addresses.
   localparam logic [1:0] SB_ADR_CSR  = 2'b00;
   localparam logic [1:0] SB_ADR_SR   = 2'b01;
   localparam logic [1:0] SB_ADR_TXDR = 2'b10;
   localparam logic [1:0] SB_ADR_RXDR = 2'b11;

   localparam int unsigned SB_TIMEOUT_CYC_DEF = 255;

   // Round-robin successor of owner g among n requesters.
   function automatic logic [1:0] next_ptr(input logic [1:0] g, input int unsigned n);
      if (32'(g) + 32'd1 >= n) return 2'd0;
      return g + 2'd1;
   endfunction

endpackage

// File: rtl/sb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo N_REQ, wins.
module rr_pick #(
   parameter int unsigned N_REQ = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [1:0]       ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic             valid_o
);

   // Scan requesters in priority order starting from ptr_i.
   always_comb begin
      int unsigned pos;
      logic        found;
      gnt_o = '0;
      found = 1'b0;
      pos   = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         pos = 32'(ptr_i) + k;
         if (pos >= N_REQ) pos = pos - N_REQ;
         for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!found && j == pos && req_i[j]) begin
               gnt_o[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/sb_arbiter.sv
// Round-robin arbiter sharing the SPI IP system-bus register port between
// up to four requesters, with bus locking that keeps spi_cs low across a
// multi-access SPI frame.
// Optional ACK watchdog: define SB_ARB_TIMEOUT_EN to abort an access after
// TIMEOUT_CYC cycles without SBACKo (pulses req_err). Undefined: XFER waits
// forever and req_err is tied low.
module sb_arbiter
   import sb_pkg::*;
#(
   parameter int unsigned N_REQ       = 2,
   parameter int unsigned TIMEOUT_CYC = SB_TIMEOUT_CYC_DEF
) (
   input  logic               SBCLKi,
   input  logic               RSTn,
   input  logic [N_REQ-1:0]   req_stb,
   input  logic [N_REQ-1:0]   req_wr,
   input  logic [2*N_REQ-1:0] req_adr,
   input  logic [8*N_REQ-1:0] req_dat,
   input  logic [N_REQ-1:0]   req_lock,
   output logic [N_REQ-1:0]   req_ack,
   output logic [N_REQ-1:0]   req_err,
   output logic [7:0]         req_rdata,
   output logic [N_REQ-1:0]   grant,
   output logic               SBSTBi,
   output logic               SBWRi,
   output logic [1:0]         SBADRi,
   output logic [7:0]         SBDATi,
   input  logic [7:0]         SBDATo,
   input  logic               SBACKo,
   output logic               spi_cs
);

   if (N_REQ < 2 || N_REQ > 4) begin : g_bad_nreq
      $error("sb_arbiter: N_REQ must be in 2..4");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_bad_timeout
      $error("sb_arbiter: TIMEOUT_CYC must be in 1..1023");
   end

   sb_state_e        state_q, state_d;
   logic [1:0]       ptr_q, ptr_d, gidx_q, gidx_d, ptr_adv;
   logic [N_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
   logic             stb_q, stb_d, wr_q, wr_d, cs_q, cs_d;
   logic [1:0]       adr_q, adr_d;
   logic [7:0]       dat_q, dat_d, rdata_q, rdata_d;

   logic [N_REQ-1:0] pick_gnt;
   logic             pick_vld;
   logic [1:0]       pick_idx, sel, sel_adr;
   logic             sel_stb, sel_wr, sel_lock;
   logic [7:0]       sel_dat;

`ifdef SB_ARB_TIMEOUT_EN
   logic [N_REQ-1:0] err_q, err_d;
   logic [9:0]       cnt_q, cnt_d;
   assign req_err = err_q;
`else
   assign req_err = '0;
`endif

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i   (req_stb),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_vld)
   );

   assign ptr_adv = next_ptr(gidx_q, N_REQ);

   // Encode the picker's one-hot winner as an index.
   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++)
         if (pick_gnt[i]) pick_idx = 2'(i);
   end

   // Select the fields of the candidate (IDLE) or current owner (other states).
   always_comb begin
      sel      = (state_q == ST_IDLE) ? pick_idx : gidx_q;
      sel_stb  = 1'b0;
      sel_wr   = 1'b0;
      sel_lock = 1'b0;
      sel_adr  = '0;
      sel_dat  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (sel == 2'(i)) begin
            sel_stb  = req_stb[i];
            sel_wr   = req_wr[i];
            sel_lock = req_lock[i];
            sel_adr  = req_adr[2*i +: 2];
            sel_dat  = req_dat[8*i +: 8];
         end
      end
   end

   // Next-state and registered-output logic of the arbitration FSM.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      stb_d   = stb_q;
      wr_d    = wr_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rdata_d = rdata_q;
      cs_d    = cs_q;
      ack_d   = '0;
`ifdef SB_ARB_TIMEOUT_EN
      err_d   = '0;
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               gidx_d  = pick_idx;
               grant_d = pick_gnt;
               stb_d   = 1'b1;
               wr_d    = sel_wr;
               adr_d   = sel_adr;
               dat_d   = sel_dat;
`ifdef SB_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (SBACKo) begin
               stb_d   = 1'b0;
               wr_d    = 1'b0;
               adr_d   = '0;
               dat_d   = '0;
               rdata_d = SBDATo;
               ack_d   = grant_q;
               state_d = ST_RESP;
            end
`ifdef SB_ARB_TIMEOUT_EN
            else if (cnt_q == 10'(TIMEOUT_CYC - 1)) begin
               stb_d   = 1'b0;
               wr_d    = 1'b0;
               adr_d   = '0;
               dat_d   = '0;
               err_d   = grant_q;
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_q + 10'd1;
            end
`endif
         end
         ST_RESP: begin
            if (sel_lock) begin
               cs_d    = 1'b0;
               state_d = ST_HOLD;
            end else begin
               cs_d    = 1'b1;
               ptr_d   = ptr_adv;
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (sel_stb) begin
               stb_d   = 1'b1;
               wr_d    = sel_wr;
               adr_d   = sel_adr;
               dat_d   = sel_dat;
`ifdef SB_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
               state_d = ST_XFER;
            end else if (!sel_lock) begin
               cs_d    = 1'b1;
               ptr_d   = ptr_adv;
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
`ifdef SB_ARB_TIMEOUT_EN
         ST_ERR: begin
            cs_d    = 1'b1;
            ptr_d   = ptr_adv;
            grant_d = '0;
            state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge SBCLKi) begin
      if (!RSTn) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         stb_q   <= 1'b0;
         wr_q    <= 1'b0;
         adr_q   <= SB_ADR_CSR;
         dat_q   <= '0;
         rdata_q <= '0;
         cs_q    <= 1'b1;
         ack_q   <= '0;
`ifdef SB_ARB_TIMEOUT_EN
         err_q   <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         stb_q   <= stb_d;
         wr_q    <= wr_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rdata_q <= rdata_d;
         cs_q    <= cs_d;
         ack_q   <= ack_d;
`ifdef SB_ARB_TIMEOUT_EN
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign req_ack   = ack_q;
   assign req_rdata = rdata_q;
   assign grant     = grant_q;
   assign SBSTBi    = stb_q;
   assign SBWRi     = wr_q;
   assign SBADRi    = adr_q;
   assign SBDATi    = dat_q;
   assign spi_cs    = cs_q;

endmodule

// File: tb/tb_sb_arbiter.sv
// Scoreboard bench for sb_arbiter: directed accesses push expected
// transactions; a monitor thread checks bus strobes and ack/err pulses.
module tb_sb_arbiter;
   import sb_pkg::*;

   localparam int unsigned N = 2;
   localparam int unsigned TB_TIMEOUT = 8;

   logic           SBCLKi = 1'b0;
   logic           RSTn = 1'b0;
   logic [N-1:0]   req_stb = '0, req_wr = '0, req_lock = '0;
   logic [2*N-1:0] req_adr = '0;
   logic [8*N-1:0] req_dat = '0;
   logic [N-1:0]   req_ack, req_err, grant;
   logic [7:0]     req_rdata;
   logic           SBSTBi, SBWRi;
   logic [1:0]     SBADRi;
   logic [7:0]     SBDATi;
   logic [7:0]     SBDATo = '0;
   logic           SBACKo = 1'b0;
   logic           spi_cs;

   sb_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
      .SBCLKi(SBCLKi), .RSTn(RSTn),
      .req_stb(req_stb), .req_wr(req_wr), .req_adr(req_adr), .req_dat(req_dat),
      .req_lock(req_lock), .req_ack(req_ack), .req_err(req_err),
      .req_rdata(req_rdata), .grant(grant),
      .SBSTBi(SBSTBi), .SBWRi(SBWRi), .SBADRi(SBADRi), .SBDATi(SBDATi),
      .SBDATo(SBDATo), .SBACKo(SBACKo), .spi_cs(spi_cs)
   );

   always #5 SBCLKi = ~SBCLKi;

   typedef struct {
      int         idx;
      bit         is_err;
      bit         wr;
      logic [1:0] adr;
      logic [7:0] dat;
      logic [7:0] rdata;
      bit         cs;
      int         stb_cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int unsigned ack_delay = 1;
   int unsigned noack_req = 0;
   int unsigned stray_req = 0;
   logic [7:0]  rsp_data [0:15];

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int idx, input bit is_err, input bit wr, input logic [1:0] adr,
                           input logic [7:0] dat, input logic [7:0] rdata, input bit cs,
                           input int stb_cyc);
      exp_t e;
      e.idx = idx; e.is_err = is_err; e.wr = wr; e.adr = adr; e.dat = dat;
      e.rdata = rdata; e.cs = cs; e.stb_cyc = stb_cyc;
      exp_q.push_back(e);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_stb"}, 32'(SBSTBi), 0);
      chk({tag, "_wr"}, 32'(SBWRi), 0);
      chk({tag, "_adr"}, 32'(SBADRi), 0);
      chk({tag, "_dat"}, 32'(SBDATi), 0);
      chk({tag, "_ack"}, 32'(req_ack), 0);
      chk({tag, "_err"}, 32'(req_err), 0);
      chk({tag, "_rdata"}, 32'(req_rdata), 0);
      chk({tag, "_grant"}, 32'(grant), 0);
      chk({tag, "_cs"}, 32'(spi_cs), 1);
   endtask

   // One requester access: raise stb, wait (bounded) for ack/err, drop stb.
   task automatic do_access(input int i, input bit wr, input logic [1:0] adr,
                            input logic [7:0] dat, input bit lock);
      int n;
      @(posedge SBCLKi); #1;
      req_stb[i] = 1'b1;
      req_wr[i] = wr;
      req_adr[2*i +: 2] = adr;
      req_dat[8*i +: 8] = dat;
      req_lock[i] = lock;
      n = 0;
      do begin
         @(negedge SBCLKi);
         n++;
      end while (!(req_ack[i] || req_err[i]) && n < 2000);
      if (!(req_ack[i] || req_err[i])) begin
         total++;
         bad++;
         $display("FAIL wait_ack_req%0d: no ack/err after %0d cycles", i, n);
      end
      @(posedge SBCLKi); #1;
      req_stb[i] = 1'b0;
   endtask

   initial begin
      rsp_data[0] = 8'h11; rsp_data[1] = 8'h22; rsp_data[2] = 8'h33;
      rsp_data[3] = 8'h3C; rsp_data[4] = 8'h06; rsp_data[5] = 8'hC0;
      rsp_data[6] = 8'h00; rsp_data[7] = 8'h77; rsp_data[8] = 8'h9A;
      rsp_data[9] = 8'h4B; rsp_data[10] = 8'hB4; rsp_data[11] = 8'hD2;
      for (int i = 12; i < 16; i++) rsp_data[i] = 8'hEE;

      fork
         begin : responder
            int unsigned cnt, rsp_n, noack_done, stray_done;
            bit skip;
            cnt = 0; rsp_n = 0; noack_done = 0; stray_done = 0; skip = 1'b0;
            forever begin
               @(posedge SBCLKi); #1;
               if (SBACKo) begin
                  SBACKo = 1'b0;
                  cnt = 0;
               end else if (stray_req != stray_done) begin
                  stray_done++;
                  SBDATo = 8'h5A;
                  SBACKo = 1'b1;
               end else if (SBSTBi) begin
                  cnt++;
                  if (cnt == 1) begin
                     skip = (noack_req != noack_done);
                     if (skip) noack_done++;
                  end
                  if (!skip && cnt == ack_delay + 1) begin
                     SBDATo = rsp_data[rsp_n];
                     rsp_n++;
                     SBACKo = 1'b1;
                  end
               end else begin
                  cnt = 0;
               end
            end
         end
         begin : monitor
            int   stb_cnt;
            exp_t e;
            stb_cnt = 0;
            forever begin
               @(negedge SBCLKi);
               if (!RSTn) begin
                  stb_cnt = 0;
               end else begin
                  if (SBSTBi) begin
                     if (stb_cnt == 0) begin
                        if (exp_q.size() == 0) begin
                           chk("stb_unexpected", 32'(SBSTBi), 0);
                        end else begin
                           e = exp_q[0];
                           chk("stb_grant", 32'(grant), 32'(oh(e.idx)));
                           chk("stb_wr", 32'(SBWRi), 32'(e.wr));
                           chk("stb_adr", 32'(SBADRi), 32'(e.adr));
                           chk("stb_dat", 32'(SBDATi), 32'(e.dat));
                           chk("stb_cs", 32'(spi_cs), 32'(e.cs));
                        end
                     end
                     stb_cnt++;
                  end
                  if (|req_ack || |req_err) begin
                     if (exp_q.size() == 0) begin
                        chk("resp_unexpected", 32'({req_err, req_ack}), 0);
                     end else begin
                        e = exp_q.pop_front();
                        if (e.is_err) begin
                           chk("err_pulse", 32'(req_err), 32'(oh(e.idx)));
                           chk("err_noack", 32'(req_ack), 0);
                        end else begin
                           chk("ack_pulse", 32'(req_ack), 32'(oh(e.idx)));
                           chk("ack_noerr", 32'(req_err), 0);
                           chk("ack_rdata", 32'(req_rdata), 32'(e.rdata));
                        end
                        chk("resp_stb_low", 32'(SBSTBi), 0);
                        chk("resp_grant", 32'(grant), 32'(oh(e.idx)));
                        chk("resp_cs", 32'(spi_cs), 32'(e.cs));
                        chk("resp_stb_cycles", 32'(stb_cnt), 32'(e.stb_cyc));
                     end
                     stb_cnt = 0;
                  end
               end
            end
         end
         begin : watchdog
            #200000;
            $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
            $fatal(1, "global timeout");
         end
      join_none

      // Reset values.
      repeat (2) @(posedge SBCLKi);
      @(negedge SBCLKi);
      chk_reset("rst");
      @(posedge SBCLKi); #1;
      RSTn = 1'b1;

      // Contention from reset: 0, then 1, then 0 again.
      ack_delay = 1;
      push_exp(0, 0, 1, SB_ADR_SR,   8'h01, 8'h11, 1, 2);
      push_exp(1, 0, 1, SB_ADR_CSR,  8'h80, 8'h22, 1, 2);
      push_exp(0, 0, 0, SB_ADR_RXDR, 8'h00, 8'h33, 1, 2);
      fork
         begin
            do_access(0, 1, SB_ADR_SR, 8'h01, 0);
            do_access(0, 0, SB_ADR_RXDR, 8'h00, 0);
         end
         do_access(1, 1, SB_ADR_CSR, 8'h80, 0);
      join
      repeat (3) @(posedge SBCLKi);

      // Single write, ACK two cycles after STB.
      ack_delay = 2;
      push_exp(0, 0, 1, SB_ADR_TXDR, 8'hA5, 8'h3C, 1, 3);
      do_access(0, 1, SB_ADR_TXDR, 8'hA5, 0);
      repeat (3) @(posedge SBCLKi);

      // Stray SBACKo while idle.
      stray_req++;
      repeat (4) @(negedge SBCLKi);
      chk("stray_rdata", 32'(req_rdata), 32'h3C);
      chk("stray_ack", 32'(req_ack), 0);
      chk("stray_grant", 32'(grant), 0);

      // Locked read sequence on req 1 while req 0 waits.
      ack_delay = 1;
      push_exp(1, 0, 0, SB_ADR_RXDR, 8'h00, 8'h06, 1, 2);
      push_exp(1, 0, 0, SB_ADR_RXDR, 8'h00, 8'hC0, 0, 2);
      push_exp(1, 0, 0, SB_ADR_SR,   8'h00, 8'h00, 0, 2);
      push_exp(0, 0, 1, SB_ADR_TXDR, 8'h5E, 8'h77, 1, 2);
      fork
         begin
            do_access(1, 0, SB_ADR_RXDR, 8'h00, 1);
            do_access(1, 0, SB_ADR_RXDR, 8'h00, 1);
            do_access(1, 0, SB_ADR_SR, 8'h00, 0);
         end
         do_access(0, 1, SB_ADR_TXDR, 8'h5E, 0);
      join
      repeat (3) @(posedge SBCLKi);

      // Reset while holding a lock.
      push_exp(0, 0, 0, SB_ADR_SR, 8'h00, 8'h9A, 1, 2);
      do_access(0, 0, SB_ADR_SR, 8'h00, 1);
      repeat (2) @(negedge SBCLKi);
      chk("hold_cs", 32'(spi_cs), 0);
      chk("hold_grant", 32'(grant), 32'(oh(0)));
      @(posedge SBCLKi); #1;
      RSTn = 1'b0;
      @(posedge SBCLKi); #1;
      RSTn = 1'b1;
      req_lock[0] = 1'b0;
      @(negedge SBCLKi);
      chk_reset("hold_rst");
      repeat (2) @(posedge SBCLKi);

      // Pointer back at 0 after reset: req 0 wins a tie.
      push_exp(0, 0, 1, SB_ADR_CSR, 8'h12, 8'h4B, 1, 2);
      push_exp(1, 0, 1, SB_ADR_CSR, 8'h34, 8'hB4, 1, 2);
      fork
         do_access(0, 1, SB_ADR_CSR, 8'h12, 0);
         do_access(1, 1, SB_ADR_CSR, 8'h34, 0);
      join
      repeat (3) @(posedge SBCLKi);

`ifdef SB_ARB_TIMEOUT_EN
      // ACK watchdog: req 0 never acked, then req 1 served.
      noack_req++;
      push_exp(0, 1, 1, SB_ADR_CSR, 8'hE1, 8'h00, 1, 8);
      push_exp(1, 0, 0, SB_ADR_SR,  8'h00, 8'hD2, 1, 2);
      fork
         do_access(0, 1, SB_ADR_CSR, 8'hE1, 0);
         begin
            @(posedge SBCLKi);
            do_access(1, 0, SB_ADR_SR, 8'h00, 0);
         end
      join
      repeat (3) @(posedge SBCLKi);
`endif

      repeat (3) @(negedge SBCLKi);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      chk("final_cs", 32'(spi_cs), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sb_arbiter.md
# sb_arbiter

Round-robin arbiter that shares the single SPI IP system-bus register port (SBSTBi/SBWRi/SBADRi/SBDATi/SBDATo/SBACKo) between up to four requesters, for example the ADC sampling controller and a configuration/UART-driven register path. A requester can lock the bus across several register accesses so that one SPI frame is never interleaved with another. The arbiter owns the SPI chip select and holds it low for the whole locked sequence. It sits between the requesters and the SPI hard IP. It also provides an optional ACK watchdog.

## Interface
- N_REQ, 2, number of requesters (2..4)
- TIMEOUT_CYC, 255, maximum cycles in XFER without SBACKo before abort (1..1023)

- SBCLKi  in  1  system-bus clock
- RSTn  in  1  reset; synchronous and active-low
- req_stb  in  N_REQ  per-requester access request; held until req_ack or req_err
- req_wr  in  N_REQ  1 = write, 0 = read
- req_adr  in  2*N_REQ  register address; requester i uses bits [2i+1:2i]
- req_dat  in  8*N_REQ  write data; requester i uses bits [8i+7:8i]
- req_lock  in  N_REQ  keep ownership and assert chip select after this access
- req_ack  out  N_REQ  one-cycle completion pulse to the granted requester
- req_err  out  N_REQ  one-cycle timeout pulse
- req_rdata  out  8  SBDATo captured at ACK; valid while req_ack is high, held until the next ACK
- grant  out  N_REQ  one-hot current owner; 0 when idle
- SBSTBi, SBWRi  out  1  bus strobe and write
- SBADRi  out  2  bus address
- SBDATi  out  8  bus write data
- SBDATo  in  8  bus read data
- SBACKo  in  1  bus acknowledge
- spi_cs  out  1  SPI chip select, active low

## Operation
- FSM states: IDLE, XFER, RESP, HOLD, and ERR when the watchdog is compiled in.
- IDLE
  - Scan req_stb starting at index ptr, wrapping modulo N_REQ.
  - The first set bit g wins: latch its wr/adr/dat into the bus registers, set SBSTBi=1 and grant=onehot(g), then go to XFER.
  - If no requests, stay in IDLE.
- XFER
  - Bus outputs stay constant.
  - On SBACKo=1: SBSTBi, SBWRi, SBADRi and SBDATi go to 0; capture SBDATo into req_rdata; req_ack[g]=1; go to RESP.
  - SBACKo in any other state is ignored.
- RESP (one cycle)
  - The requester must drop req_stb[g] on the edge that ends RESP.
  - If req_lock[g]=1: set spi_cs=0 and go to HOLD.
  - Otherwise: set spi_cs=1, ptr=(g+1) mod N_REQ, grant=0, and go to IDLE.
- HOLD
  - Only requester g is served.
  - req_stb[g]=1: latch its fields and go to XFER.
  - req_stb[g]=0 and req_lock[g]=0: set spi_cs=1, advance ptr, clear grant, and go to IDLE.
  - Requests from other requesters wait indefinitely.
- Simultaneous requests are resolved by ptr; the most recent owner has the lowest priority.
- Address width is exactly 2 bits; no address decoding.
- Reset values: SBSTBi=0, SBWRi=0, SBADRi=0, SBDATi=0, req_ack=0, req_err=0, req_rdata=0, grant=0, spi_cs=1, ptr=0, state=IDLE.
- Reset asserted mid-XFER or mid-HOLD: the strobe drops and chip select releases on the next edge; the pending access is lost and no ack is issued.

## Timing
- Request seen in IDLE at cycle c: SBSTBi=1 from cycle c+1.
- SBACKo at cycle a: req_ack and req_rdata valid at cycle a+1, and SBSTBi=0 at a+1.
- Back-to-back accesses: next arbitration (IDLE or HOLD) at cycle a+2, next SBSTBi at a+3, giving a minimum 4-cycle access when ACK arrives one cycle after STB.
- spi_cs falls at the end of the RESP cycle of the first locked access and rises one cycle after the owner drops both stb and lock in HOLD.

## Configuration
- SB_ARB_TIMEOUT_EN defined:
  - A 10-bit counter clears on entry to XFER and increments each XFER cycle.
  - If it reaches TIMEOUT_CYC without SBACKo: clear the bus outputs, go to ERR.
  - ERR (one cycle): pulse req_err[g], set spi_cs=1, force-release any lock, advance ptr, go to IDLE.
- Undefined: XFER waits forever, req_err is tied to 0, and the counter and ERR state are absent.

## Structure
- Shared package sb_pkg: state encoding, SB register address constants (CSR=2'b00, SR=2'b01, TXDR=2'b10, RXDR=2'b11), and the TIMEOUT_CYC default.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are the request vector and ptr; outputs are the one-hot winner and a valid flag.

## Test plan
- Single write: req 0 writes adr=2 dat=8'hA5 with SBACKo two cycles after STB -> SBADRi=2, SBDATi=8'hA5, one req_ack[0] pulse, spi_cs stays 1.
- Contention: req 0 and req 1 request simultaneously from reset -> req 0 is served first, then req 1, then req 0 again if it is still requesting.
- Locked read sequence: req 1 issues three reads with lock=1 on the first two, while req 0 requests throughout -> no req 0 access between them, spi_cs low from the first RESP until after the third, and req_rdata matches SBDATo values 8'h06, 8'hC0, 8'h00.
- Timeout (macro on, TIMEOUT_CYC=8): SBACKo never asserted -> SBSTBi drops after 8 XFER cycles, req_err[0] pulses, spi_cs=1, and req 1 is then granted.
- Reset mid-HOLD: RSTn low for one cycle -> every output reaches its reset value at the next edge and no ack is issued.
- Stray SBACKo in IDLE -> no req_ack and req_rdata unchanged.
